// File: rtl/unidade_controle_exp6.sv
// -----------------------------------------------------------------------------
// unidade_controle_exp6
//
// Moore control unit for the exp6 memory game. It steps the datapath through
// preparation, rounds, plays and the three end states. A game has 16 rounds,
// and round N needs N+1 correct plays (memory addresses 0..N).
//
// Ports
//   clock                : system clock, rising edge
//   reset                : asynchronous, active-low; forces inicial
//   iniciar              : start/restart request (level)
//   fimRod               : round counter at its last round
//   igual                : registered play matches memory data
//   enderecoIgualRodada  : address counter equals round counter
//   jogada_feita         : one-cycle play pulse
//   fimT                 : play timer expired
//   zeraE/contaE         : address counter clear / enable
//   zeraRod/contaRod     : round counter clear / enable
//   zeraT/contaT         : play timer clear / enable
//   zeraR/registraR      : play register clear / load
//   pronto               : game over (any outcome)
//   ganhou/perdeu/timeout: outcome flags
//   db_estado            : current state code for the debug display
// -----------------------------------------------------------------------------
module unidade_controle_exp6 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimRod,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       jogada_feita,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Codes are visible on db_estado and must not be re-encoded.
    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_nova_rodada    = 4'h2,
        st_espera_jogada  = 4'h3,
        st_registra       = 4'h4,
        st_comparacao     = 4'h5,
        st_proximo        = 4'h6,
        st_proxima_rodada = 4'h7,
        st_fim_acertou    = 4'hA,
        st_fim_timeout    = 4'hD,
        st_fim_errou      = 4'hE
    } state_t;

    state_t state;
    state_t next_state;

    // NOTE: state register uses non-blocking assignments so every flop samples
    // the pre-edge value of next_state; blocking here would race other blocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= st_inicial;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            st_inicial:        if (iniciar) next_state = st_preparacao;
            st_preparacao:     next_state = st_nova_rodada;
            st_nova_rodada:    next_state = st_espera_jogada;
            st_espera_jogada: begin
                // A play landing in the same cycle as expiry still counts.
                if (jogada_feita)  next_state = st_registra;
                else if (fimT)     next_state = st_fim_timeout;
            end
            st_registra:       next_state = st_comparacao;
            st_comparacao: begin
                if (!igual)                              next_state = st_fim_errou;
                else if (enderecoIgualRodada && fimRod)  next_state = st_fim_acertou;
                else if (enderecoIgualRodada)            next_state = st_proxima_rodada;
                else                                     next_state = st_proximo;
            end
            st_proximo:        next_state = st_espera_jogada;
            st_proxima_rodada: next_state = st_nova_rodada;
            st_fim_acertou,
            st_fim_errou,
            st_fim_timeout:    if (iniciar) next_state = st_preparacao;
            // Any code outside the enum recovers to idle.
            default:           next_state = st_inicial;
        endcase
    end

    // Moore output decode: a pure function of the state register.
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraRod   = 1'b0;
        contaRod  = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        timeout   = 1'b0;
        case (state)
            st_preparacao: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
            end
            st_nova_rodada: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            st_espera_jogada:  contaT = 1'b1;
            st_registra: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            st_proximo: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            st_proxima_rodada: contaRod = 1'b1;
            st_fim_acertou: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            st_fim_errou: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            st_fim_timeout: begin
                pronto  = 1'b1;
                perdeu  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_exp6.sv
module tb_unidade_controle_exp6;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, fimRod, igual, enderecoIgualRodada, jogada_feita, fimT;
    logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT;
    logic       zeraR, registraR, pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    unidade_controle_exp6 dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .fimRod              (fimRod),
        .igual               (igual),
        .enderecoIgualRodada (enderecoIgualRodada),
        .jogada_feita        (jogada_feita),
        .fimT                (fimT),
        .zeraE               (zeraE),
        .contaE              (contaE),
        .zeraRod             (zeraRod),
        .contaRod            (contaRod),
        .zeraT               (zeraT),
        .contaT              (contaT),
        .zeraR               (zeraR),
        .registraR           (registraR),
        .pronto              (pronto),
        .ganhou              (ganhou),
        .perdeu              (perdeu),
        .timeout             (timeout),
        .db_estado           (db_estado)
    );

    always #5 clock = ~clock;

    // Output bit order used throughout the bench:
    // {zeraE,contaE,zeraRod,contaRod,zeraT,contaT,zeraR,registraR,pronto,ganhou,perdeu,timeout}
    localparam logic [11:0] O_ZE = 12'h800, O_CE = 12'h400, O_ZROD = 12'h200, O_CROD = 12'h100;
    localparam logic [11:0] O_ZT = 12'h080, O_CT = 12'h040, O_ZR = 12'h020, O_RR = 12'h010;
    localparam logic [11:0] O_PR = 12'h008, O_GA = 12'h004, O_PE = 12'h002, O_TO = 12'h001;

    wire [11:0] dut_out = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT,
                           zeraR, registraR, pronto, ganhou, perdeu, timeout};

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model (game rules as a table) ----------------
    int m_state;

    function automatic int model_next(int s, bit ini, bit jf, bit ft, bit ig, bit eq, bit fr);
        case (s)
            0:  return ini ? 1 : 0;
            1:  return 2;
            2:  return 3;
            3:  return jf ? 4 : (ft ? 13 : 3);
            4:  return 5;
            5:  return !ig ? 14 : ((eq && fr) ? 10 : (eq ? 7 : 6));
            6:  return 3;
            7:  return 2;
            10, 13, 14: return ini ? 1 : s;
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] model_out(int s);
        case (s)
            1:  return O_ZE | O_ZROD | O_ZR | O_ZT;
            2:  return O_ZE | O_ZT;
            3:  return O_CT;
            4:  return O_RR | O_ZT;
            6:  return O_CE | O_ZT;
            7:  return O_CROD;
            10: return O_PR | O_GA;
            14: return O_PR | O_PE;
            13: return O_PR | O_PE | O_TO;
            default: return 12'h000;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m_state <= 0;
        else        m_state <= model_next(m_state, iniciar, jogada_feita, fimT,
                                          igual, enderecoIgualRodada, fimRod);
    end

    // Compare process: every falling edge, DUT against the model.
    always @(negedge clock) begin
        check("model_state", {12'h0, db_estado}, 16'(m_state));
        check("model_outs", {4'h0, dut_out}, {4'h0, model_out(m_state)});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [3:0] st, input logic [11:0] outs);
        check({name, "_state"}, {12'h0, db_estado}, {12'h0, st});
        check({name, "_outs"}, {4'h0, dut_out}, {4'h0, outs});
    endtask

    // Drives one play from espera_jogada through comparacao's decision.
    task automatic play(input bit ig, input bit eq, input bit fr);
        igual = ig; enderecoIgualRodada = eq; fimRod = fr;
        jogada_feita = 1'b1;
        step(); jogada_feita = 1'b0;
        expect_st("registra", 4'h4, 12'h090);
        step();
        expect_st("comparacao", 4'h5, 12'h000);
        step();
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; fimRod = 1'b0; igual = 1'b0;
        enderecoIgualRodada = 1'b0; jogada_feita = 1'b0; fimT = 1'b0;
        #2;
        expect_st("reset", 4'h0, 12'h000);
        #10 reset = 1'b1;
        repeat (5) step();
        expect_st("idle", 4'h0, 12'h000);

        // Start
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_st("prep", 4'h1, 12'hAA0);
        step(); expect_st("nova", 4'h2, 12'h880);
        step(); expect_st("espera", 4'h3, 12'h040);

        // Round 0 correct
        play(1'b1, 1'b1, 1'b0);
        expect_st("prox_rod", 4'h7, 12'h100);
        step(); expect_st("nova_r1", 4'h2, 12'h880);
        step();
        step(); step();
        expect_st("hold_wait", 4'h3, 12'h040);

        // Round 1: first play mid-round, second closes the round
        play(1'b1, 1'b0, 1'b0);
        expect_st("proximo", 4'h6, 12'h480);
        step(); expect_st("back_wait", 4'h3, 12'h040);
        play(1'b1, 1'b1, 1'b0);
        expect_st("prox_rod2", 4'h7, 12'h100);
        step(); step();

        // Wrong play
        play(1'b0, 1'b0, 1'b0);
        expect_st("errou", 4'hE, 12'h00A);
        step(); step();
        expect_st("errou_hold", 4'hE, 12'h00A);
        iniciar = 1'b1; #1;
        expect_st("errou_ini", 4'hE, 12'h00A);
        step(); iniciar = 1'b0;
        expect_st("restart", 4'h1, 12'hAA0);
        step(); step();

        // Timeout
        fimT = 1'b1; step(); fimT = 1'b0;
        expect_st("timeout", 4'hD, 12'h00B);
        iniciar = 1'b1; step(); iniciar = 1'b0;
        expect_st("restart2", 4'h1, 12'hAA0);
        step(); step();

        // Play and expiry together: play wins; then final win
        fimT = 1'b1; igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b1;
        jogada_feita = 1'b1;
        step(); jogada_feita = 1'b0; fimT = 1'b0;
        expect_st("tie_registra", 4'h4, 12'h090);
        step(); step();
        expect_st("acertou", 4'hA, 12'h00C);
        step(); expect_st("acertou_hold", 4'hA, 12'h00C);

        // Restart then asynchronous reset mid-game
        iniciar = 1'b1; step(); iniciar = 1'b0;
        step(); step();
        expect_st("pre_reset", 4'h3, 12'h040);
        #2 reset = 1'b0;
        #1 expect_st("async_reset", 4'h0, 12'h000);
        #3 reset = 1'b1;
        step(); step();
        expect_st("after_reset", 4'h0, 12'h000);

        @(negedge clock); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
